// File: rtl/control_pipe_pkg.sv
// Shared control bundle, bubble value and forwarding-select encodings for control_pipe.
// Pure types and constants: no latency, no flow control.
package control_pipe_pkg;

   localparam int CTRL_ALUOP_W = 2;

   typedef struct packed {
      logic                    alu_src;
      logic                    result_src;
      logic                    reg_write;
      logic [CTRL_ALUOP_W-1:0] alu_op;
      logic                    mem_write;
      logic                    branch;
   } ctrl_t;

   // All-zero control has no architectural side effect anywhere downstream.
   localparam ctrl_t BUBBLE = '0;

   typedef enum logic [1:0] {
      FWD_REG = 2'b00,
      FWD_WB  = 2'b01,
      FWD_MEM = 2'b10
   } fwd_t;

endpackage

// File: rtl/control_pipe_hazard_fwd_unit.sv
// Combinational load-use detect, beq flush and EX operand forwarding selects.
// Zero latency; flush overrides stall so a killed slot never holds the front end.
module hazard_fwd_unit
   import control_pipe_pkg::*;
#(
   parameter int REG_ADDR_W = 5
) (
   input  logic                  id_valid,
   input  logic                  id_alu_src,
   input  logic                  id_mem_write,
   input  logic [REG_ADDR_W-1:0] id_rs1,
   input  logic [REG_ADDR_W-1:0] id_rs2,
   input  logic                  ex_reg_write,
   input  logic                  ex_result_src,
   input  logic                  ex_branch,
   input  logic [REG_ADDR_W-1:0] ex_rs1,
   input  logic [REG_ADDR_W-1:0] ex_rs2,
   input  logic [REG_ADDR_W-1:0] ex_rd,
   input  logic                  zero,
   input  logic                  mem_reg_write,
   input  logic [REG_ADDR_W-1:0] mem_rd,
   input  logic                  wb_reg_write,
   input  logic [REG_ADDR_W-1:0] wb_rd,
   output logic                  stall,
   output logic                  flush,
   output logic [1:0]            fwd_a,
   output logic [1:0]            fwd_b
);

   logic ex_load;
   logic rs2_used;
   logic hz;

   function automatic logic [1:0] fwd_sel(input logic [REG_ADDR_W-1:0] rs,
                                          input logic mem_we, input logic [REG_ADDR_W-1:0] mem_d,
                                          input logic wb_we, input logic [REG_ADDR_W-1:0] wb_d);
      // x0 is hardwired, so a write to it must never be forwarded.
      if (mem_we && (mem_d != '0) && (mem_d == rs))
         return FWD_MEM;
      else if (wb_we && (wb_d != '0) && (wb_d == rs))
         return FWD_WB;
      else
         return FWD_REG;
   endfunction

   always_comb begin
      ex_load  = ex_reg_write & ex_result_src;
      rs2_used = ~id_alu_src | id_mem_write;
      hz       = id_valid & ex_load & (ex_rd != '0) &
                 ((id_rs1 == ex_rd) | (rs2_used & (id_rs2 == ex_rd)));
      flush    = ex_branch & zero;
      stall    = hz & ~flush;
      fwd_a    = fwd_sel(ex_rs1, mem_reg_write, mem_rd, wb_reg_write, wb_rd);
      fwd_b    = fwd_sel(ex_rs2, mem_reg_write, mem_rd, wb_reg_write, wb_rd);
   end

endmodule

// File: rtl/control_pipe.sv
// ID/EX, EX/MEM, MEM/WB control stage registers with load-use stall, beq flush and forwarding.
// One cycle per stage; only ID/EX is gated (bubble on stall/flush/invalid), later stages always advance.
module control_pipe
   import control_pipe_pkg::*;
#(
   parameter int REG_ADDR_W = 5,
   parameter int ALUOP_W    = 2
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  id_valid_i,
   input  logic                  ALUSrc_i,
   input  logic                  ResultSrc_i,
   input  logic                  RegWrite_i,
   input  logic [ALUOP_W-1:0]    ALUOp_i,
   input  logic                  MemWrite_i,
   input  logic                  Branch_i,
   input  logic [REG_ADDR_W-1:0] RS1addr_i,
   input  logic [REG_ADDR_W-1:0] RS2addr_i,
   input  logic [REG_ADDR_W-1:0] RDaddr_i,
   input  logic                  Zero_i,
   output logic                  EX_ALUSrc_o,
   output logic [ALUOP_W-1:0]    EX_ALUOp_o,
   output logic                  EX_Branch_o,
   output logic                  MEM_MemWrite_o,
   output logic [REG_ADDR_W-1:0] MEM_RDaddr_o,
   output logic                  WB_RegWrite_o,
   output logic                  WB_ResultSrc_o,
   output logic [REG_ADDR_W-1:0] WB_RDaddr_o,
   output logic [1:0]            FwdA_o,
   output logic [1:0]            FwdB_o,
   output logic                  Stall_o,
   output logic                  Flush_o
);

   ctrl_t                 id_ctrl, ex_ctrl;
   logic [REG_ADDR_W-1:0] ex_rs1, ex_rs2, ex_rd;
   logic                  mem_reg_write, mem_result_src, mem_mem_write;
   logic [REG_ADDR_W-1:0] mem_rd;
   logic                  wb_reg_write, wb_result_src;
   logic [REG_ADDR_W-1:0] wb_rd;
   logic                  id_take;

   // ResultSrc is masked so an undriven value on non-writing instructions never enters the pipe.
   always_comb begin
      id_ctrl            = BUBBLE;
      id_ctrl.alu_src    = ALUSrc_i;
      id_ctrl.result_src = ResultSrc_i & RegWrite_i;
      id_ctrl.reg_write  = RegWrite_i;
      id_ctrl.alu_op     = ALUOp_i;
      id_ctrl.mem_write  = MemWrite_i;
      id_ctrl.branch     = Branch_i;
      id_take            = id_valid_i & ~Stall_o & ~Flush_o;
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         ex_ctrl        <= BUBBLE;
         ex_rs1         <= '0;
         ex_rs2         <= '0;
         ex_rd          <= '0;
         mem_reg_write  <= 1'b0;
         mem_result_src <= 1'b0;
         mem_mem_write  <= 1'b0;
         mem_rd         <= '0;
         wb_reg_write   <= 1'b0;
         wb_result_src  <= 1'b0;
         wb_rd          <= '0;
      end else begin
         ex_ctrl        <= id_take ? id_ctrl : BUBBLE;
         ex_rs1         <= id_take ? RS1addr_i : '0;
         ex_rs2         <= id_take ? RS2addr_i : '0;
         ex_rd          <= id_take ? RDaddr_i : '0;
         mem_reg_write  <= ex_ctrl.reg_write;
         mem_result_src <= ex_ctrl.result_src;
         mem_mem_write  <= ex_ctrl.mem_write;
         mem_rd         <= ex_rd;
         wb_reg_write   <= mem_reg_write;
         wb_result_src  <= mem_result_src;
         wb_rd          <= mem_rd;
      end
   end

   hazard_fwd_unit #(.REG_ADDR_W(REG_ADDR_W)) u_hazard_fwd (
      .id_valid      (id_valid_i),
      .id_alu_src    (ALUSrc_i),
      .id_mem_write  (MemWrite_i),
      .id_rs1        (RS1addr_i),
      .id_rs2        (RS2addr_i),
      .ex_reg_write  (ex_ctrl.reg_write),
      .ex_result_src (ex_ctrl.result_src),
      .ex_branch     (ex_ctrl.branch),
      .ex_rs1        (ex_rs1),
      .ex_rs2        (ex_rs2),
      .ex_rd         (ex_rd),
      .zero          (Zero_i),
      .mem_reg_write (mem_reg_write),
      .mem_rd        (mem_rd),
      .wb_reg_write  (wb_reg_write),
      .wb_rd         (wb_rd),
      .stall         (Stall_o),
      .flush         (Flush_o),
      .fwd_a         (FwdA_o),
      .fwd_b         (FwdB_o)
   );

   assign EX_ALUSrc_o    = ex_ctrl.alu_src;
   assign EX_ALUOp_o     = ex_ctrl.alu_op;
   assign EX_Branch_o    = ex_ctrl.branch;
   assign MEM_MemWrite_o = mem_mem_write;
   assign MEM_RDaddr_o   = mem_rd;
   assign WB_RegWrite_o  = wb_reg_write;
   assign WB_ResultSrc_o = wb_result_src;
   assign WB_RDaddr_o    = wb_rd;

endmodule

// File: tb/tb_control_pipe.sv
// Directed bench for control_pipe: an instruction-level pipeline model checked every cycle,
// plus hand-computed literal checks at the interesting points of each scenario.
module tb_control_pipe;

   logic       clk_i = 1'b0;
   logic       rst_i = 1'b1;
   logic       id_valid_i = 1'b0, ALUSrc_i = 1'b0, ResultSrc_i = 1'b0, RegWrite_i = 1'b0;
   logic [1:0] ALUOp_i = 2'b00;
   logic       MemWrite_i = 1'b0, Branch_i = 1'b0, Zero_i = 1'b0;
   logic [4:0] RS1addr_i = '0, RS2addr_i = '0, RDaddr_i = '0;
   logic       EX_ALUSrc_o, EX_Branch_o, MEM_MemWrite_o, WB_RegWrite_o, WB_ResultSrc_o;
   logic [1:0] EX_ALUOp_o, FwdA_o, FwdB_o;
   logic [4:0] MEM_RDaddr_o, WB_RDaddr_o;
   logic       Stall_o, Flush_o;

   int n_cmp = 0;
   int n_bad = 0;

   control_pipe #(.REG_ADDR_W(5), .ALUOP_W(2)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .id_valid_i(id_valid_i), .ALUSrc_i(ALUSrc_i),
      .ResultSrc_i(ResultSrc_i), .RegWrite_i(RegWrite_i), .ALUOp_i(ALUOp_i),
      .MemWrite_i(MemWrite_i), .Branch_i(Branch_i), .RS1addr_i(RS1addr_i),
      .RS2addr_i(RS2addr_i), .RDaddr_i(RDaddr_i), .Zero_i(Zero_i),
      .EX_ALUSrc_o(EX_ALUSrc_o), .EX_ALUOp_o(EX_ALUOp_o), .EX_Branch_o(EX_Branch_o),
      .MEM_MemWrite_o(MEM_MemWrite_o), .MEM_RDaddr_o(MEM_RDaddr_o),
      .WB_RegWrite_o(WB_RegWrite_o), .WB_ResultSrc_o(WB_ResultSrc_o),
      .WB_RDaddr_o(WB_RDaddr_o), .FwdA_o(FwdA_o), .FwdB_o(FwdB_o),
      .Stall_o(Stall_o), .Flush_o(Flush_o)
   );

   always #5 clk_i = ~clk_i;

   // ---------------- instruction-level model ----------------
   typedef struct packed {
      logic       alusrc, loads, writes;
      logic [1:0] aluop;
      logic       stores, branch;
      logic [4:0] rs1, rs2, rd;
   } ins_t;

   ins_t m_ex = '0, m_mem = '0, m_wb = '0;

   function automatic logic id_reads(input logic [4:0] r);
      return (RS1addr_i == r) || ((!ALUSrc_i || MemWrite_i) && (RS2addr_i == r));
   endfunction

   function automatic logic m_flush();
      return m_ex.branch && Zero_i;
   endfunction

   function automatic logic m_stall();
      logic load_use;
      load_use = id_valid_i && m_ex.writes && m_ex.loads && (m_ex.rd != 0) && id_reads(m_ex.rd);
      return load_use && !m_flush();
   endfunction

   function automatic logic [1:0] m_fwd(input logic [4:0] rs);
      if (rs == 0) return 2'd0;
      if (m_mem.writes && m_mem.rd == rs) return 2'd2;
      if (m_wb.writes && m_wb.rd == rs) return 2'd1;
      return 2'd0;
   endfunction

   function automatic logic [22:0] m_out();
      return {m_ex.alusrc, m_ex.aluop, m_ex.branch, m_mem.stores, m_mem.rd,
              m_wb.writes, m_wb.loads, m_wb.rd, m_fwd(m_ex.rs1), m_fwd(m_ex.rs2),
              m_stall(), m_flush()};
   endfunction

   always @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         m_ex = '0; m_mem = '0; m_wb = '0;
      end else begin
         logic take;
         take  = id_valid_i && !m_flush() && !m_stall();
         m_wb  = m_mem;
         m_mem = m_ex;
         if (take)
            m_ex = '{alusrc: ALUSrc_i, loads: (RegWrite_i ? ResultSrc_i : 1'b0),
                     writes: RegWrite_i, aluop: ALUOp_i, stores: MemWrite_i,
                     branch: Branch_i, rs1: RS1addr_i, rs2: RS2addr_i, rd: RDaddr_i};
         else
            m_ex = '0;
      end
   end

   logic [22:0] exp_vec, act_vec;
   always @(negedge clk_i) begin
      exp_vec = m_out();
      act_vec = {EX_ALUSrc_o, EX_ALUOp_o, EX_Branch_o, MEM_MemWrite_o, MEM_RDaddr_o,
                 WB_RegWrite_o, WB_ResultSrc_o, WB_RDaddr_o, FwdA_o, FwdB_o, Stall_o, Flush_o};
      n_cmp++;
      if ($isunknown(act_vec) || act_vec !== exp_vec) begin
         n_bad++;
         $display("FAIL cycle_model t=%0t dut=%b model=%b", $time, act_vec, exp_vec);
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic lit(input string nm, input logic [7:0] act, input logic [7:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic drive(input logic v, input logic alusrc, input logic rsrc, input logic rw,
                        input logic [1:0] aluop, input logic mw, input logic br,
                        input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                        input logic zero);
      id_valid_i = v; ALUSrc_i = alusrc; ResultSrc_i = rsrc; RegWrite_i = rw;
      ALUOp_i = aluop; MemWrite_i = mw; Branch_i = br;
      RS1addr_i = rs1; RS2addr_i = rs2; RDaddr_i = rd; Zero_i = zero;
   endtask

   task automatic step(input logic v, input logic alusrc, input logic rsrc, input logic rw,
                       input logic [1:0] aluop, input logic mw, input logic br,
                       input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                       input logic zero);
      @(posedge clk_i);
      #1;
      drive(v, alusrc, rsrc, rw, aluop, mw, br, rs1, rs2, rd, zero);
      #1;
   endtask

   task automatic nop(input logic zero);
      step(0, 0, 0, 0, 2'b00, 0, 0, 5'd0, 5'd0, 5'd0, zero);
   endtask

   initial begin
      #2 rst_i = 1'b0;
      @(posedge clk_i); @(posedge clk_i); #1;
      lit("reset_stall", Stall_o, 0);
      lit("reset_flush", Flush_o, 0);
      lit("reset_fwda", FwdA_o, 0);
      lit("reset_wb_rd", WB_RDaddr_o, 0);
      @(posedge clk_i); #1 rst_i = 1'b1;

      // forwarding from EX/MEM, then MEM/WB
      step(1, 0, 0, 1, 2'b10, 0, 0, 5'd1, 5'd2, 5'd3, 0);   // add x3
      step(1, 0, 0, 1, 2'b10, 0, 0, 5'd3, 5'd3, 5'd4, 0);   // sub x4,x3,x3
      step(1, 1, 0, 1, 2'b10, 0, 0, 5'd3, 5'd0, 5'd6, 0);   // ori x6,x3
      lit("fwd_mem_a", FwdA_o, 2);
      lit("fwd_mem_b", FwdB_o, 2);
      nop(0);
      lit("fwd_wb_a", FwdA_o, 1);
      lit("fwd_x0_b", FwdB_o, 0);

      // write to x0 is not forwarded
      step(1, 0, 0, 1, 2'b10, 0, 0, 5'd1, 5'd2, 5'd0, 0);
      step(1, 0, 0, 1, 2'b10, 0, 0, 5'd0, 5'd0, 5'd8, 0);
      nop(0);
      lit("fwd_x0_a", FwdA_o, 0);

      // x7 in both EX/MEM and MEM/WB: the younger one wins
      step(1, 1, 0, 1, 2'b00, 0, 0, 5'd1, 5'd0, 5'd7, 0);
      step(1, 1, 0, 1, 2'b00, 0, 0, 5'd2, 5'd0, 5'd7, 0);
      step(1, 0, 0, 1, 2'b10, 0, 0, 5'd7, 5'd2, 5'd9, 0);
      nop(0);
      lit("fwd_prio_a", FwdA_o, 2);

      // load-use: one stall cycle then WB forwarding
      step(1, 1, 1, 1, 2'b00, 0, 0, 5'd1, 5'd0, 5'd5, 0);   // lw x5
      step(1, 0, 0, 1, 2'b10, 0, 0, 5'd5, 5'd2, 5'd6, 0);   // add x6,x5,x2
      lit("lu_stall", Stall_o, 1);
      step(1, 0, 0, 1, 2'b10, 0, 0, 5'd5, 5'd2, 5'd6, 0);   // held add
      lit("lu_stall_once", Stall_o, 0);
      lit("lu_bubble_alusrc", EX_ALUSrc_o, 0);
      nop(0);
      lit("lu_fwd_wb", FwdA_o, 1);

      // beq taken kills the following instruction
      step(1, 0, 0, 0, 2'b01, 0, 1, 5'd1, 5'd2, 5'd0, 0);
      step(1, 0, 0, 1, 2'b10, 0, 0, 5'd1, 5'd2, 5'd10, 1);
      lit("br_taken_flush", Flush_o, 1);
      nop(0);
      lit("br_taken_bubble", EX_ALUOp_o, 0);

      // beq not taken lets it proceed
      step(1, 0, 0, 0, 2'b01, 0, 1, 5'd1, 5'd2, 5'd0, 0);
      step(1, 0, 0, 1, 2'b10, 0, 0, 5'd1, 5'd2, 5'd10, 0);
      lit("br_nt_flush", Flush_o, 0);
      nop(0);
      lit("br_nt_proceed", EX_ALUOp_o, 2);

      // EX bundle that both loads and branches: taken flush must suppress the stall
      step(1, 1, 1, 1, 2'b01, 0, 1, 5'd1, 5'd0, 5'd5, 0);
      step(1, 0, 0, 1, 2'b10, 0, 0, 5'd5, 5'd2, 5'd6, 1);
      lit("fs_flush", Flush_o, 1);
      lit("fs_stall", Stall_o, 0);

      // sw with undriven ResultSrc
      step(1, 1, 1'bx, 0, 2'b00, 1, 0, 5'd1, 5'd5, 5'd0, 0);
      lit("fs_bubble_branch", EX_Branch_o, 0);
      nop(0);
      nop(0);
      lit("sw_mem_write", MEM_MemWrite_o, 1);
      nop(0);
      lit("sw_wb_resultsrc", WB_ResultSrc_o, 0);
      lit("sw_wb_regwrite", WB_RegWrite_o, 0);

      // asynchronous reset mid-stream, then refill
      step(1, 0, 0, 1, 2'b10, 0, 0, 5'd1, 5'd2, 5'd11, 0);
      step(1, 0, 0, 1, 2'b10, 0, 0, 5'd1, 5'd2, 5'd12, 0);
      nop(0);
      lit("pre_rst_mem_rd", MEM_RDaddr_o, 11);
      #1 rst_i = 1'b0;
      #1;
      lit("rst_mem_rd", MEM_RDaddr_o, 0);
      lit("rst_ex_aluop", EX_ALUOp_o, 0);
      lit("rst_wb_rd", WB_RDaddr_o, 0);
      @(posedge clk_i);
      #1 rst_i = 1'b1;
      drive(1, 0, 0, 1, 2'b10, 0, 0, 5'd1, 5'd2, 5'd13, 0);
      #1;
      nop(0);
      nop(0);
      lit("refill_mem_rd", MEM_RDaddr_o, 13);
      lit("refill_wb_early", WB_RDaddr_o, 0);
      nop(0);
      lit("refill_wb_rd", WB_RDaddr_o, 13);
      lit("refill_wb_we", WB_RegWrite_o, 1);

      nop(0);
      nop(0);
      @(posedge clk_i); #1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/control_pipe.md
Name: control_pipe

Overview:
- Consumer side of the main control decoder: takes the ID-stage control bundle and carries it through the ID/EX, EX/MEM and MEM/WB stage registers.
- Detects load-use hazards and generates the stall signal.
- Resolves beq taken in EX and generates the flush signal.
- Produces operand forwarding selects for the EX-stage ALU. Sits between the decoder/register file and the datapath stage muxes.

Parameters:
REG_ADDR_W, 5, register address width
ALUOP_W, 2, ALUOp field width

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  asynchronous, active-low reset
id_valid_i  in  1  ID holds a real instruction
ALUSrc_i  in  1  ID control from decoder
ResultSrc_i  in  1  ID control; may be X when RegWrite_i=0
RegWrite_i  in  1  ID control
ALUOp_i  in  ALUOP_W  ID control
MemWrite_i  in  1  ID control
Branch_i  in  1  ID control
RS1addr_i  in  REG_ADDR_W  ID source 1
RS2addr_i  in  REG_ADDR_W  ID source 2
RDaddr_i  in  REG_ADDR_W  ID destination
Zero_i  in  1  EX ALU zero flag
EX_ALUSrc_o  out  1  ID/EX control
EX_ALUOp_o  out  ALUOP_W  ID/EX control
EX_Branch_o  out  1  ID/EX control
MEM_MemWrite_o  out  1  EX/MEM control
MEM_RDaddr_o  out  REG_ADDR_W  EX/MEM destination
WB_RegWrite_o  out  1  MEM/WB control
WB_ResultSrc_o  out  1  MEM/WB: 1 = memory data
WB_RDaddr_o  out  REG_ADDR_W  MEM/WB destination
FwdA_o  out  2  ALU operand A select
FwdB_o  out  2  ALU operand B select
Stall_o  out  1  hold PC and IF/ID; combinational
Flush_o  out  1  kill IF/ID; combinational

Behaviour:
- Reset, asynchronous on rst_i low: all stage registers take the bubble value (all controls 0, addresses 0). Outputs become 0, FwdA_o/FwdB_o = 2'b00, Stall_o = 0, Flush_o = 0.
- Bubble: all-zero control with rd = 0. It produces no side effects downstream.
- Captured ResultSrc = ResultSrc_i & RegWrite_i, so X never enters the pipe.
- ID/EX next value:
  - bubble if Flush_o, Stall_o or !id_valid_i;
  - else the ID bundle (controls plus RS1/RS2/RD).
- EX/MEM and MEM/WB advance every cycle and are never stalled.
- Latency: one cycle per stage. An ID bundle at edge n appears in EX after n, in MEM after n+1, in WB after n+2.
- Load-use:
  - ex_load = ID/EX RegWrite & ID/EX ResultSrc;
  - rs2_used = !ALUSrc_i | MemWrite_i;
  - hz = id_valid_i & ex_load & ex_rd != 0 & (RS1addr_i == ex_rd | (rs2_used & RS2addr_i == ex_rd)).
- Flush_o = EX_Branch_o & Zero_i.
- Stall_o = hz & !Flush_o. Flush wins when both occur in the same cycle.
- Stall lasts exactly one cycle: the load moves to MEM and the bubble clears hz.
- Forwarding, per operand, with EX source = ID/EX rs:
  - 2'b10 if MEM RegWrite & MEM_rd != 0 & MEM_rd == rs;
  - else 2'b01 if WB_RegWrite_o & WB_rd != 0 & WB_rd == rs;
  - else 2'b00.
  - EX/MEM priority over MEM/WB.
  - x0 is never forwarded.
  - EX/MEM is never a load when forwarded, guaranteed by the stall.
- FwdB_o is computed on the rs2 address regardless of ALUSrc; the datapath applies ALUSrc after forwarding.
- Reset mid-operation drops all in-flight bundles immediately. There is no pending state after release.

Decomposition:
- Shared package: control bundle struct (ALUSrc, ResultSrc, RegWrite, ALUOp, MemWrite, Branch), BUBBLE constant, FWD_REG / FWD_WB / FWD_MEM encodings.
- One natural sub-module: hazard_fwd_unit (combinational hz, Flush_o, FwdA_o/FwdB_o). The stage registers stay in control_pipe.

Test Plan:
- Reset → outputs: hold rst_i low mid-stream → all outputs 0 asynchronously; after release, first bundle in WB appears 3 edges later.
- Load-use: lw x5 (ResultSrc=1, RegWrite=1, RD=5), then add with RS1=5 → Stall_o=1 for exactly 1 cycle, EX holds bubble, FwdA_o=01 when the add reaches EX.
- Forwarding: add x3, then sub using RS1=3 and RS2=3 → FwdA_o=FwdB_o=10. Add a third instruction using x3 → 01. Writes to x0 → 00.
- Forwarding priority: x7 written by both EX/MEM and MEM/WB → FwdA_o=10.
- Branch taken: beq in EX with Zero_i=1 → Flush_o=1, next EX is bubble. Same beq with Zero_i=0 → Flush_o=0, instruction proceeds.
- Flush beats stall: beq taken in EX while ID has load-use on a prior lw → Flush_o=1, Stall_o=0. sw with ResultSrc_i=X → WB_ResultSrc_o=0, no X on outputs.
